// File: rtl/ex_stage_if.sv
// ex_stage_if: ID->EX payload, EX->MEM/ID results and the data SRAM request.
//   slave  : the EX stage view (consumes ID payload and ms_allowin, drives the rest)
//   master : the surrounding pipeline view (ID, MEM and SRAM side)
interface ex_stage_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 19;
  localparam int unsigned AW   = 5;
  localparam int unsigned WEW  = 4;

  // handshake
  logic            ms_allowin;
  logic            es_allowin;
  logic            ds_to_es_valid;
  logic            es_to_ms_valid;

  // ID payload
  logic [XLEN-1:0] ds_pc;
  logic [XLEN-1:0] ds_alu_src1;
  logic [XLEN-1:0] ds_alu_src2;
  logic [XLEN-1:0] ds_rkd_value;
  logic [OPW-1:0]  ds_alu_op;
  logic            ds_res_from_mem;
  logic            ds_mem_we;
  logic            ds_rf_we;
  logic [AW-1:0]   ds_rf_waddr;

  // EX results towards MEM and forwarding to ID
  logic [XLEN-1:0] es_pc;
  logic [XLEN-1:0] es_alu_result;
  logic            es_res_from_mem;
  logic            es_rf_we;
  logic [AW-1:0]   es_rf_waddr;

  // data SRAM request
  logic            data_sram_en;
  logic [WEW-1:0]  data_sram_we;
  logic [XLEN-1:0] data_sram_addr;
  logic [XLEN-1:0] data_sram_wdata;

  modport slave (
    input  ms_allowin, ds_to_es_valid,
    input  ds_pc, ds_alu_src1, ds_alu_src2, ds_rkd_value,
    input  ds_alu_op, ds_res_from_mem, ds_mem_we, ds_rf_we, ds_rf_waddr,
    output es_allowin, es_to_ms_valid,
    output es_pc, es_alu_result, es_res_from_mem, es_rf_we, es_rf_waddr,
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport master (
    output ms_allowin, ds_to_es_valid,
    output ds_pc, ds_alu_src1, ds_alu_src2, ds_rkd_value,
    output ds_alu_op, ds_res_from_mem, ds_mem_we, ds_rf_we, ds_rf_waddr,
    input  es_allowin, es_to_ms_valid,
    input  es_pc, es_alu_result, es_res_from_mem, es_rf_we, es_rf_waddr,
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline.
//   Single-cycle ALU (add/sub/compare/logic/shift/lui/mul) plus a 32-step
//   radix-2 restoring divider for div/mod, signed and unsigned.
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : ex_stage_if.slave (ID payload in, MEM/forwarding/SRAM out)
module ex_stage (
  input  logic       clk,
  input  logic       resetn,
  ex_stage_if.slave  bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 19;
  localparam int unsigned AW   = 5;
  localparam int unsigned WEW  = 4;
  localparam int unsigned CNTW = 5;
  localparam logic [XLEN-1:0] PC_RST    = 32'h1bff_ffff;
  localparam logic [CNTW-1:0] LAST_STEP = CNTW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  // pipeline payload
  logic            r_es_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_src1;
  logic [XLEN-1:0] r_src2;
  logic [XLEN-1:0] r_rkd;
  logic [OPW-1:0]  r_alu_op;
  logic            r_res_from_mem;
  logic            r_mem_we;
  logic            r_rf_we;
  logic [AW-1:0]   r_rf_waddr;

  // divider state
  div_state_e      r_state;
  div_state_e      w_state_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic            r_q_neg;
  logic            r_r_neg;
  logic            r_dz;

  // handshake
  logic            w_es_ready_go;
  logic            w_es_allowin;
  logic            w_es_to_ms_valid;

  // FSM decoded controls
  logic            w_div_start;
  logic            w_div_step;
  logic            w_div_done;

  // op class decode
  logic            w_div_op;
  logic            w_div_signed;

  assign w_div_op     = |r_alu_op[18:15];
  assign w_div_signed = r_alu_op[15] | r_alu_op[17];

  assign w_es_allowin     = ~r_es_valid | (w_es_ready_go & bus.ms_allowin);
  assign w_es_to_ms_valid = r_es_valid & w_es_ready_go;
  // Div ops stall until the divider reaches DONE; everything else is single-cycle.
  assign w_es_ready_go    = ~w_div_op | w_div_done;

  // ID -> EX payload register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_es_valid     <= 1'b0;
      r_pc           <= PC_RST;
      r_src1         <= '0;
      r_src2         <= '0;
      r_rkd          <= '0;
      r_alu_op       <= '0;
      r_res_from_mem <= 1'b0;
      r_mem_we       <= 1'b0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= '0;
    end else begin
      if (w_es_allowin) begin
        r_es_valid <= bus.ds_to_es_valid;
      end
      if (w_es_allowin && bus.ds_to_es_valid) begin
        r_pc           <= bus.ds_pc;
        r_src1         <= bus.ds_alu_src1;
        r_src2         <= bus.ds_alu_src2;
        r_rkd          <= bus.ds_rkd_value;
        r_alu_op       <= bus.ds_alu_op;
        r_res_from_mem <= bus.ds_res_from_mem;
        r_mem_we       <= bus.ds_mem_we;
        r_rf_we        <= bus.ds_rf_we;
        r_rf_waddr     <= bus.ds_rf_waddr;
      end
    end
  end

  // single-cycle ALU
  logic [XLEN-1:0]   w_add;
  logic [XLEN-1:0]   w_sub;
  logic [XLEN-1:0]   w_slt;
  logic [XLEN-1:0]   w_sltu;
  logic [4:0]        w_shamt;
  logic [XLEN-1:0]   w_sll;
  logic [XLEN-1:0]   w_srl;
  logic [XLEN-1:0]   w_sra;
  logic signed [2*XLEN-1:0] w_prod_s;
  logic [2*XLEN-1:0] w_prod_u;

  assign w_add    = r_src1 + r_src2;
  assign w_sub    = r_src1 - r_src2;
  assign w_slt    = {{(XLEN-1){1'b0}}, ($signed(r_src1) < $signed(r_src2))};
  assign w_sltu   = {{(XLEN-1){1'b0}}, (r_src1 < r_src2)};
  assign w_shamt  = r_src2[4:0];
  assign w_sll    = r_src1 << w_shamt;
  assign w_srl    = r_src1 >> w_shamt;
  assign w_sra    = $unsigned($signed(r_src1) >>> w_shamt);
  // Operands are extended to 64 bits so the low 64 bits of the product are exact.
  assign w_prod_s = $signed({{XLEN{r_src1[XLEN-1]}}, r_src1})
                  * $signed({{XLEN{r_src2[XLEN-1]}}, r_src2});
  assign w_prod_u = {{XLEN{1'b0}}, r_src1} * {{XLEN{1'b0}}, r_src2};

  // divider operand magnitudes; |0x80000000| wraps back to 0x80000000, which is exact unsigned
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;

  assign w_abs_a = (w_div_signed && r_src1[XLEN-1]) ? -r_src1 : r_src1;
  assign w_abs_b = (w_div_signed && r_src2[XLEN-1]) ? -r_src2 : r_src2;

  // one restoring step: shift the next dividend bit into the partial remainder
  logic [XLEN:0]   w_shift;
  logic            w_fits;
  logic [XLEN-1:0] w_diff;

  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_fits  = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = XLEN'(w_shift - {1'b0, r_dvs});

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (r_es_valid && w_div_op)                 w_state_nxt = S_BUSY;
      S_BUSY: if (r_cnt == LAST_STEP)                     w_state_nxt = S_DONE;
      S_DONE: if (w_es_to_ms_valid && bus.ms_allowin)     w_state_nxt = S_IDLE;
      default:                                            w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_div_start = 1'b0;
    w_div_step  = 1'b0;
    w_div_done  = 1'b0;
    unique case (r_state)
      S_IDLE:  w_div_start = r_es_valid & w_div_op;
      S_BUSY:  w_div_step  = 1'b1;
      S_DONE:  w_div_done  = 1'b1;
      default: w_div_start = 1'b0;
    endcase
  end

  // divider datapath: latch magnitudes on start, retire one quotient bit per step
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_dz    <= 1'b0;
    end else if (w_div_start) begin
      r_cnt   <= '0;
      r_quo   <= w_abs_a;
      r_rem   <= '0;
      r_dvs   <= w_abs_b;
      r_q_neg <= w_div_signed & (r_src1[XLEN-1] ^ r_src2[XLEN-1]);
      r_r_neg <= w_div_signed & r_src1[XLEN-1];
      r_dz    <= (r_src2 == '0);
    end else if (w_div_step) begin
      r_cnt   <= r_cnt + CNTW'(1);
      r_rem   <= w_fits ? w_diff : w_shift[XLEN-1:0];
      r_quo   <= {r_quo[XLEN-2:0], w_fits};
    end
  end

  // signed fix-up; divide by zero forces all-ones quotient and returns the dividend
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;

  assign w_quo_fix = r_dz ? '1     : (r_q_neg ? -r_quo : r_quo);
  assign w_rem_fix = r_dz ? r_src1 : (r_r_neg ? -r_rem : r_rem);

  // one-hot result select
  logic [XLEN-1:0] w_alu_result;

  assign w_alu_result = ({XLEN{r_alu_op[0]}}  & w_add)
                      | ({XLEN{r_alu_op[1]}}  & w_sub)
                      | ({XLEN{r_alu_op[2]}}  & w_slt)
                      | ({XLEN{r_alu_op[3]}}  & w_sltu)
                      | ({XLEN{r_alu_op[4]}}  & (r_src1 & r_src2))
                      | ({XLEN{r_alu_op[5]}}  & ~(r_src1 | r_src2))
                      | ({XLEN{r_alu_op[6]}}  & (r_src1 | r_src2))
                      | ({XLEN{r_alu_op[7]}}  & (r_src1 ^ r_src2))
                      | ({XLEN{r_alu_op[8]}}  & w_sll)
                      | ({XLEN{r_alu_op[9]}}  & w_srl)
                      | ({XLEN{r_alu_op[10]}} & w_sra)
                      | ({XLEN{r_alu_op[11]}} & r_src2)
                      | ({XLEN{r_alu_op[12]}} & w_prod_s[XLEN-1:0])
                      | ({XLEN{r_alu_op[13]}} & w_prod_s[2*XLEN-1:XLEN])
                      | ({XLEN{r_alu_op[14]}} & w_prod_u[2*XLEN-1:XLEN])
                      | ({XLEN{r_alu_op[15] | r_alu_op[16]}} & w_quo_fix)
                      | ({XLEN{r_alu_op[17] | r_alu_op[18]}} & w_rem_fix)
                      // low product bits are unused by the unsigned high-word op
                      | ({XLEN{1'b0}} & w_prod_u[XLEN-1:0]);

  // outputs
  assign bus.es_allowin      = w_es_allowin;
  assign bus.es_to_ms_valid  = w_es_to_ms_valid;
  assign bus.es_pc           = r_pc;
  assign bus.es_alu_result   = w_alu_result;
  assign bus.es_res_from_mem = r_res_from_mem;
  // an empty stage must not look like a pending register write to ID
  assign bus.es_rf_we        = r_rf_we & r_es_valid;
  assign bus.es_rf_waddr     = r_rf_waddr;
  assign bus.data_sram_en    = r_es_valid & (r_res_from_mem | r_mem_we);
  assign bus.data_sram_we    = {WEW{r_mem_we & r_es_valid}};
  assign bus.data_sram_addr  = w_alu_result;
  assign bus.data_sram_wdata = r_rkd;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
module tb_ex_stage;
  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;

  ex_stage_if bus ();

  ex_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // op encodings (one-hot)
  localparam logic [18:0] OP_ADD   = 19'h00001;
  localparam logic [18:0] OP_SUB   = 19'h00002;
  localparam logic [18:0] OP_SLT   = 19'h00004;
  localparam logic [18:0] OP_SLTU  = 19'h00008;
  localparam logic [18:0] OP_AND   = 19'h00010;
  localparam logic [18:0] OP_NOR   = 19'h00020;
  localparam logic [18:0] OP_OR    = 19'h00040;
  localparam logic [18:0] OP_XOR   = 19'h00080;
  localparam logic [18:0] OP_SLL   = 19'h00100;
  localparam logic [18:0] OP_SRL   = 19'h00200;
  localparam logic [18:0] OP_SRA   = 19'h00400;
  localparam logic [18:0] OP_LUI   = 19'h00800;
  localparam logic [18:0] OP_MUL   = 19'h01000;
  localparam logic [18:0] OP_MULH  = 19'h02000;
  localparam logic [18:0] OP_MULHU = 19'h04000;
  localparam logic [18:0] OP_DIV   = 19'h08000;
  localparam logic [18:0] OP_DIVU  = 19'h10000;
  localparam logic [18:0] OP_MOD   = 19'h20000;
  localparam logic [18:0] OP_MODU  = 19'h40000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [18:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] rkd, input logic rfm, input logic mwe,
                      input logic rfwe, input logic [4:0] wa, input logic [31:0] pc);
    bus.ds_to_es_valid  = 1'b1;
    bus.ds_alu_op       = op;
    bus.ds_alu_src1     = a;
    bus.ds_alu_src2     = b;
    bus.ds_rkd_value    = rkd;
    bus.ds_res_from_mem = rfm;
    bus.ds_mem_we       = mwe;
    bus.ds_rf_we        = rfwe;
    bus.ds_rf_waddr     = wa;
    bus.ds_pc           = pc;
  endtask

  // single-cycle op: accept, then check result in the following cycle
  task automatic alu(input string tag, input logic [18:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    send(op, a, b, 32'h0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h1c00_0010);
    tick();
    chk({tag, "_valid"}, 32'(bus.es_to_ms_valid), 32'd1);
    chk(tag, bus.es_alu_result, exp);
  endtask

  // div op: accept at cycle N, count cycles until es_to_ms_valid, check result in DONE
  task automatic run_div(input string tag, input logic [18:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int   lat;
    logic blk_ok;
    send(op, a, b, 32'h0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h1c00_0040);
    tick();
    bus.ds_to_es_valid = 1'b0;
    lat    = 0;
    blk_ok = 1'b1;
    while (bus.es_to_ms_valid !== 1'b1 && lat < 40) begin
      if (bus.es_allowin !== 1'b0) blk_ok = 1'b0;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd33);
    chk({tag, "_allowin_blocked"}, 32'(blk_ok), 32'd1);
    chk({tag, "_result"}, bus.es_alu_result, exp);
    chk({tag, "_allowin_done"}, 32'(bus.es_allowin), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn             = 1'b0;
    bus.ms_allowin     = 1'b1;
    bus.ds_to_es_valid = 1'b0;
    send(OP_ADD, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    bus.ds_to_es_valid = 1'b0;

    // reset state
    tick();
    chk("rst_to_ms_valid", 32'(bus.es_to_ms_valid), 32'd0);
    chk("rst_allowin", 32'(bus.es_allowin), 32'd1);
    chk("rst_pc", bus.es_pc, 32'h1bff_ffff);
    chk("rst_rf_we", 32'(bus.es_rf_we), 32'd0);
    chk("rst_sram_en", 32'(bus.data_sram_en), 32'd0);
    chk("rst_sram_we", 32'(bus.data_sram_we), 32'd0);
    resetn = 1'b1;
    tick();

    // add overflow wraps, forwarding fields visible the cycle after acceptance
    send(OP_ADD, 32'h7fff_ffff, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1c00_0000);
    tick();
    chk("add_valid", 32'(bus.es_to_ms_valid), 32'd1);
    chk("add_result", bus.es_alu_result, 32'h8000_0000);
    chk("add_rf_we", 32'(bus.es_rf_we), 32'd1);
    chk("add_rf_waddr", 32'(bus.es_rf_waddr), 32'd3);
    chk("add_pc", bus.es_pc, 32'h1c00_0000);
    chk("add_sram_en", 32'(bus.data_sram_en), 32'd0);

    // back-to-back single-cycle ops
    alu("sub",     OP_SUB,   32'h5,         32'h7,         32'hffff_fffe);
    alu("slt",     OP_SLT,   32'hffff_ffff, 32'h1,         32'h1);
    alu("sltu",    OP_SLTU,  32'hffff_ffff, 32'h1,         32'h0);
    alu("and",     OP_AND,   32'hf0f0_f0f0, 32'hff00_ff00, 32'hf000_f000);
    alu("nor",     OP_NOR,   32'h0f0f_0000, 32'h0000_00ff, 32'hf0f0_ff00);
    alu("or",      OP_OR,    32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
    alu("xor",     OP_XOR,   32'hffff_0000, 32'h0f0f_0f0f, 32'hf0f0_0f0f);
    alu("sll",     OP_SLL,   32'h1,         32'h3f,        32'h8000_0000);
    alu("srl",     OP_SRL,   32'h8000_0000, 32'h4,         32'h0800_0000);
    alu("sra",     OP_SRA,   32'h8000_0000, 32'h4,         32'hf800_0000);
    alu("lui",     OP_LUI,   32'h1111_1111, 32'habcd_e000, 32'habcd_e000);
    alu("mul_w",   OP_MUL,   32'hffff_ffff, 32'h2,         32'hffff_fffe);
    alu("mulh_w",  OP_MULH,  32'hffff_ffff, 32'h2,         32'hffff_ffff);
    alu("mulh_wu", OP_MULHU, 32'hffff_ffff, 32'h2,         32'h0000_0001);

    // store word
    send(OP_ADD, 32'h1c00_0000, 32'h0000_0100, 32'hdead_beef, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1c00_0020);
    tick();
    chk("st_sram_en", 32'(bus.data_sram_en), 32'd1);
    chk("st_sram_we", 32'(bus.data_sram_we), 32'hf);
    chk("st_sram_addr", bus.data_sram_addr, 32'h1c00_0100);
    chk("st_sram_wdata", bus.data_sram_wdata, 32'hdead_beef);
    chk("st_rf_we", 32'(bus.es_rf_we), 32'd0);

    // load word
    send(OP_ADD, 32'h1c00_0000, 32'h0000_0008, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h1c00_0024);
    tick();
    chk("ld_sram_en", 32'(bus.data_sram_en), 32'd1);
    chk("ld_sram_we", 32'(bus.data_sram_we), 32'h0);
    chk("ld_res_from_mem", 32'(bus.es_res_from_mem), 32'd1);
    chk("ld_rf_we", 32'(bus.es_rf_we), 32'd1);

    // empty stage
    bus.ds_to_es_valid = 1'b0;
    tick();
    chk("empty_valid", 32'(bus.es_to_ms_valid), 32'd0);
    chk("empty_rf_we", 32'(bus.es_rf_we), 32'd0);
    chk("empty_sram_en", 32'(bus.data_sram_en), 32'd0);

    // divider
    run_div("div_w_m7_2", OP_DIV, 32'hffff_fff9, 32'h2, 32'hffff_fffd);
    tick();
    run_div("mod_w_m7_2", OP_MOD, 32'hffff_fff9, 32'h2, 32'hffff_ffff);
    tick();
    run_div("div_w_7_m2", OP_DIV, 32'h7, 32'hffff_fffe, 32'hffff_fffd);
    tick();
    run_div("mod_w_7_m2", OP_MOD, 32'h7, 32'hffff_fffe, 32'h1);
    tick();
    run_div("div_wu_5_0", OP_DIVU, 32'h5, 32'h0, 32'hffff_ffff);
    tick();
    run_div("mod_wu_5_0", OP_MODU, 32'h5, 32'h0, 32'h5);
    tick();
    run_div("div_w_m5_0", OP_DIV, 32'hffff_fffb, 32'h0, 32'hffff_ffff);
    tick();
    run_div("mod_w_m5_0", OP_MOD, 32'hffff_fffb, 32'h0, 32'hffff_fffb);
    tick();
    run_div("div_w_ovf", OP_DIV, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000);
    tick();
    run_div("mod_w_ovf", OP_MOD, 32'h8000_0000, 32'hffff_ffff, 32'h0);
    tick();
    run_div("divu_big", OP_DIVU, 32'hffff_fff9, 32'h2, 32'h7fff_fffc);
    tick();

    // MEM back-pressure while DONE
    run_div("hold_div", OP_DIVU, 32'd100, 32'd7, 32'he);
    bus.ms_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", 32'(bus.es_to_ms_valid), 32'd1);
      chk("hold_result", bus.es_alu_result, 32'he);
      chk("hold_allowin", 32'(bus.es_allowin), 32'd0);
    end
    bus.ms_allowin = 1'b1;
    tick();
    chk("hold_release_valid", 32'(bus.es_to_ms_valid), 32'd0);
    chk("hold_release_allowin", 32'(bus.es_allowin), 32'd1);
    run_div("after_hold_mod", OP_MODU, 32'd100, 32'd7, 32'h2);
    tick();

    // reset in the middle of a division
    send(OP_DIVU, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h1c00_0080);
    tick();
    bus.ds_to_es_valid = 1'b0;
    repeat (10) tick();
    resetn = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.es_to_ms_valid), 32'd0);
    chk("midrst_allowin", 32'(bus.es_allowin), 32'd1);
    chk("midrst_pc", bus.es_pc, 32'h1bff_ffff);
    chk("midrst_rf_we", 32'(bus.es_rf_we), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    run_div("after_rst_div", OP_DIVU, 32'd100, 32'd7, 32'he);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
